id_ex_pipe_stage: RTL and testbench

- Parametrised pipeline stage for the ID→EX boundary.
- Generalises the fixed-field, always-advance decode/execute register into four things:
  - a DATA_W-wide payload register;
  - a valid/ready handshake with stall;
  - an optional 2-entry skid buffer, so in_ready_o is registered;
  - a flush with a configurable bubble value and a saturating flush-kill counter.
- Sits between the decoder/control-unit output bundle (operands, ALU ctrl, waddr, we, branch info, concatenated) and EX.

---
 rtl/id_ex_pipe_stage.sv | 118 +++++++++++
 tb/tb_id_ex_pipe_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register: valid/ready + stall, optional 2-entry skid (registered ready), flush with bubble value.
// Latency 1 cycle in->out; backpressure via in_ready_o (registered when SKID=1, combinational when SKID=0).
module id_ex_pipe_stage #(
  parameter int                DATA_W    = 112,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              take, put;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign flush_cnt_o = flush_cnt_q;

  assign take = out_valid_o & out_ready_i & ~stall_i;
  assign put  = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (put) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (put && take) begin
            main_d = in_data_i;
          end else if (put && (SKID != 0)) begin
            state_d = TWO;
            skid_d  = in_data_i;
          end else if (take) begin
            state_d = EMPTY;
            main_d  = FLUSH_VAL;
          end
        end
        TWO: begin
          if (take) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = FLUSH_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = FLUSH_VAL;
          skid_d  = FLUSH_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
      skid_q  <= FLUSH_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Counts only flushes that actually killed something; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (flush_i && (state_q != EMPTY) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  if (SKID != 0) begin : g_skid
    logic rdy_q;
    always_ff @(posedge clk) begin
      if (rst) rdy_q <= 1'b1;
      else     rdy_q <= (state_d != TWO);
    end
    assign in_ready_o = rdy_q;
  end else begin : g_noskid
    assign in_ready_o = ~out_valid_o | (out_ready_i & ~stall_i);
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage: SKID=1 instance (CNT_W=2) plus a SKID=0 instance.
module tb_id_ex_pipe_stage;

  localparam int          DW = 112;
  localparam logic [DW-1:0] FV = 112'h0F0F_A5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, stall, flush;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occ;
  logic [1:0]    fcnt;

  logic          z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_stall, z_flush;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [1:0]    z_occ;
  logic [15:0]   z_fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID(1), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .stall_i(stall), .flush_i(flush), .occupancy_o(occ), .flush_cnt_o(fcnt)
  );

  id_ex_pipe_stage #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid_i(z_in_valid), .in_ready_o(z_in_ready), .in_data_i(z_in_data),
    .out_valid_o(z_out_valid), .out_ready_i(z_out_ready), .out_data_o(z_out_data),
    .stall_i(z_stall), .flush_i(z_flush), .occupancy_o(z_occ), .flush_cnt_o(z_fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0; z_stall = 1'b0; z_flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== FV) begin n_fail++; $display("FAIL reset_data got %h exp %h", out_data, FV); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occ); end
    n_checks++; if (fcnt !== 2'd0) begin n_fail++; $display("FAIL reset_fcnt got %0d exp 0", fcnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    n_checks++; if (z_in_ready !== 1'b1 || z_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_skid0 got rdy=%b vld=%b exp 1 0", z_in_ready, z_out_valid); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp_v;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      exp_v    = DW'(i);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v || occ !== 2'd1) begin
        n_fail++; $display("FAIL stream_%0d got vld=%b data=%h occ=%0d exp 1 %h 1", i, out_valid, out_data, occ, exp_v);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== FV) begin n_fail++; $display("FAIL stream_drain got vld=%b data=%h exp 0 %h", out_valid, out_data, FV); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 112'hA;
    tick();
    in_data = 112'hB;
    n_checks++; if (in_ready !== 1'b1 || out_data !== 112'hA) begin n_fail++; $display("FAIL bp_first got rdy=%b data=%h exp 1 a", in_ready, out_data); end
    tick();
    in_data = 112'hC;
    n_checks++; if (occ !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b exp 2 0", occ, in_ready); end
    tick();
    n_checks++; if (occ !== 2'd2 || out_data !== 112'hA) begin n_fail++; $display("FAIL bp_hold got occ=%0d data=%h exp 2 a", occ, out_data); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_data !== 112'hB || occ !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_b got data=%h occ=%0d rdy=%b exp b 1 1", out_data, occ, in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 112'hC || out_valid !== 1'b1 || occ !== 2'd1) begin n_fail++; $display("FAIL bp_c got data=%h vld=%b occ=%0d exp c 1 1", out_data, out_valid, occ); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL bp_drain got vld=%b occ=%0d exp 0 0", out_valid, occ); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 112'h55;
    tick();
    in_valid = 1'b0;
    stall = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 112'h55 || occ !== 2'd1) begin
        n_fail++; $display("FAIL stall_%0d got vld=%b data=%h occ=%0d exp 1 55 1", i, out_valid, out_data, occ);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got vld=%b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 112'h11;
    tick();
    in_data = 112'h22;
    tick();
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_setup got occ=%0d exp 2", occ); end
    flush = 1'b1; in_data = 112'h33; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== FV || fcnt !== 2'd1 || in_ready !== 1'b1 || occ !== 2'd0) begin
      n_fail++; $display("FAIL flush_kill got vld=%b data=%h cnt=%0d rdy=%b occ=%0d exp 0 %h 1 1 0", out_valid, out_data, fcnt, in_ready, occ, FV);
    end
    tick();
    n_checks++; if (out_valid !== 1'b0 || fcnt !== 2'd1) begin n_fail++; $display("FAIL flush_empty got vld=%b cnt=%0d exp 0 1", out_valid, fcnt); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== FV) begin n_fail++; $display("FAIL flush_dropped got vld=%b data=%h exp 0 %h", out_valid, out_data, FV); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 16'h100);
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_checks++; if (fcnt !== exp_c) begin n_fail++; $display("FAIL sat_%0d got %0d exp %0d", i, fcnt, exp_c); end
    end
    in_valid = 1'b1; in_data = 112'h77;
    tick();
    in_data = 112'h78;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0 || fcnt !== 2'd0 || out_data !== FV || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset got vld=%b occ=%0d cnt=%0d data=%h rdy=%b exp 0 0 0 %h 1", out_valid, occ, fcnt, out_data, in_ready, FV);
    end
  endtask

  task automatic test_skid0();
    z_out_ready = 1'b0;
    z_in_valid = 1'b1; z_in_data = 112'h5;
    tick();
    z_in_valid = 1'b0;
    n_checks++; if (z_out_valid !== 1'b1 || z_out_data !== 112'h5 || z_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_hold got vld=%b data=%h rdy=%b exp 1 5 0", z_out_valid, z_out_data, z_in_ready); end
    z_out_ready = 1'b1;
    #1;
    n_checks++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_comb_ready got %b exp 1", z_in_ready); end
    z_stall = 1'b1;
    #1;
    n_checks++; if (z_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_stall_ready got %b exp 0", z_in_ready); end
    z_stall = 1'b0; z_in_valid = 1'b1; z_in_data = 112'h6;
    tick();
    z_in_valid = 1'b0;
    n_checks++; if (z_out_data !== 112'h6 || z_occ !== 2'd1) begin n_fail++; $display("FAIL s0_pass got data=%h occ=%0d exp 6 1", z_out_data, z_occ); end
    tick();
    n_checks++; if (z_out_valid !== 1'b0 || z_out_data !== FV) begin n_fail++; $display("FAIL s0_drain got vld=%b data=%h exp 0 %h", z_out_valid, z_out_data, FV); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_skid0();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
